// File: rtl/mario_motion.sv
// mario_motion: per-player motion controller (writer side of the position
// interface). Samples buttons on frame_tick, runs walk/jump/gravity physics
// in one CALC cycle and commits x, y, vel_y and motion state together so the
// display never observes a partially updated coordinate.
//
// Ports:
//   clk         system (pixel) clock
//   rst         synchronous active-high reset
//   frame_tick  one-cycle pulse per frame; starts an update when idle
//   btn_left, btn_right, btn_jump  debounced, synchronised button levels
//   mario_x     committed left column
//   mario_y     committed bottom-edge height above the floor row
//   vel_y       committed vertical velocity (signed, px/frame)
//   on_ground   high while the motion state is GROUND
//   busy        high while the update sequencer is not idle
//
// Optional feature: define JUMP_BUFFER_EN to remember a jump pressed shortly
// before landing and launch on the frame after touchdown.
module mario_motion #(
    parameter int W_MARIO    = 16,
    parameter int H_MARIO    = 16,
    parameter int X_INIT     = 100,
    parameter int X_MIN      = 2,
    parameter int X_MAX      = 598,
    parameter int Y_MAX      = 386,
    parameter int WALK_SPEED = 3,
    parameter int JUMP_VEL   = 12,
    parameter int GRAVITY    = 1,
    parameter int MAX_FALL   = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_jump,
    output logic [9:0] mario_x,
    output logic [9:0] mario_y,
    output logic [7:0] vel_y,
    output logic       on_ground,
    output logic       busy
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_COMMIT} seq_t;
    typedef enum logic [1:0] {M_GROUND, M_RISE, M_FALL} mot_t;

    localparam logic signed [10:0] X_LO     = 11'(X_MIN);
    localparam logic signed [10:0] X_HI     = 11'(X_MAX - W_MARIO);
    localparam logic signed [10:0] Y_TOP    = 11'(Y_MAX - H_MARIO);
    localparam logic signed [10:0] WALK_S   = 11'(WALK_SPEED);
    localparam logic signed [10:0] GRAV_S   = 11'(GRAVITY);
    localparam logic signed [10:0] NEG_FALL = 11'(-MAX_FALL);
    localparam logic        [9:0]  JUMP_Y   = 10'(JUMP_VEL);
    localparam logic        [7:0]  JUMP_VY  = 8'(JUMP_VEL - GRAVITY);

    seq_t seq, seq_nxt;
    mot_t mot, calc_mot, p_mot;

    logic       l_left, l_right, l_jump;
    logic [9:0] calc_x, calc_y, p_x, p_y;
    logic [7:0] calc_vy, p_vy;
    logic       launch;

    logic signed [10:0] x_cur, x_sum, y_sum, vy_cur, vy_dec;

`ifdef JUMP_BUFFER_EN
    logic [1:0] buf_cnt, calc_cnt, p_cnt;
    logic       jump_pend, calc_pend, p_pend;
`endif

    always_comb begin
        seq_nxt = seq;
        case (seq)
            S_IDLE:   if (frame_tick) seq_nxt = S_CALC;
            S_CALC:   seq_nxt = S_COMMIT;
            S_COMMIT: seq_nxt = S_IDLE;
            default:  seq_nxt = S_IDLE;
        endcase
    end

    assign busy      = (seq != S_IDLE);
    assign on_ground = (mot == M_GROUND);

`ifdef JUMP_BUFFER_EN
    assign launch = l_jump | jump_pend;
`else
    assign launch = l_jump;
`endif

    // Horizontal physics
    always_comb begin
        x_cur = $signed({1'b0, mario_x});
        x_sum = x_cur;
        if (l_left && !l_right)
            x_sum = x_cur - WALK_S;
        else if (l_right && !l_left)
            x_sum = x_cur + WALK_S;
        if (x_sum < X_LO)
            x_sum = X_LO;
        else if (x_sum > X_HI)
            x_sum = X_HI;
        calc_x = x_sum[9:0];
    end

    // Vertical physics
    always_comb begin
        vy_cur   = $signed({{3{vel_y[7]}}, vel_y});
        y_sum    = $signed({1'b0, mario_y}) + vy_cur;
        vy_dec   = vy_cur - GRAV_S;
        if (vy_dec < NEG_FALL)
            vy_dec = NEG_FALL;
        calc_y   = mario_y;
        calc_vy  = vel_y;
        calc_mot = mot;
`ifdef JUMP_BUFFER_EN
        calc_cnt  = buf_cnt;
        calc_pend = jump_pend;
`endif
        if (mot == M_GROUND) begin
            if (launch) begin
                calc_y   = JUMP_Y;
                calc_vy  = JUMP_VY;
                calc_mot = M_RISE;
            end else begin
                calc_y   = '0;
                calc_vy  = '0;
                calc_mot = M_GROUND;
            end
`ifdef JUMP_BUFFER_EN
            calc_cnt  = '0;
            calc_pend = 1'b0;
`endif
        end else begin
`ifdef JUMP_BUFFER_EN
            if (l_jump)
                calc_cnt = 2'd3;
            else if (buf_cnt != 2'd0)
                calc_cnt = buf_cnt - 2'd1;
`endif
            // Landing is checked first so it wins over the ceiling clamp.
            if (y_sum <= 11'sd0 && vy_cur < 11'sd0) begin
                calc_y   = '0;
                calc_vy  = '0;
                calc_mot = M_GROUND;
`ifdef JUMP_BUFFER_EN
                calc_pend = l_jump || (buf_cnt != 2'd0);
                calc_cnt  = '0;
`endif
            end else if (y_sum > Y_TOP) begin
                calc_y   = Y_TOP[9:0];
                calc_vy  = '0;
                calc_mot = M_FALL;
            end else begin
                calc_y   = y_sum[9:0];
                calc_vy  = vy_dec[7:0];
                calc_mot = (vy_dec > 11'sd0) ? M_RISE : M_FALL;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seq     <= S_IDLE;
            mot     <= M_GROUND;
            mario_x <= 10'(X_INIT);
            mario_y <= '0;
            vel_y   <= '0;
            l_left  <= 1'b0;
            l_right <= 1'b0;
            l_jump  <= 1'b0;
            p_x     <= '0;
            p_y     <= '0;
            p_vy    <= '0;
            p_mot   <= M_GROUND;
`ifdef JUMP_BUFFER_EN
            buf_cnt   <= '0;
            jump_pend <= 1'b0;
            p_cnt     <= '0;
            p_pend    <= 1'b0;
`endif
        end else begin
            seq <= seq_nxt;
            if (seq == S_IDLE && frame_tick) begin
                l_left  <= btn_left;
                l_right <= btn_right;
                l_jump  <= btn_jump;
            end
            if (seq == S_CALC) begin
                p_x   <= calc_x;
                p_y   <= calc_y;
                p_vy  <= calc_vy;
                p_mot <= calc_mot;
`ifdef JUMP_BUFFER_EN
                p_cnt  <= calc_cnt;
                p_pend <= calc_pend;
`endif
            end
            if (seq == S_COMMIT) begin
                mario_x <= p_x;
                mario_y <= p_y;
                vel_y   <= p_vy;
                mot     <= p_mot;
`ifdef JUMP_BUFFER_EN
                buf_cnt   <= p_cnt;
                jump_pend <= p_pend;
`endif
            end
        end
    end

endmodule

// File: tb/tb_mario_motion.sv
// Directed self-checking bench for mario_motion: reset values, walking and
// wall clamps, a full jump arc, ceiling clamp (separate instance with a low
// ceiling), optional jump buffering, reset during an update and ticks that
// must be ignored.
module tb_mario_motion;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       frame_tick = 1'b0;
    logic       btn_left = 1'b0, btn_right = 1'b0, btn_jump = 1'b0;
    logic [9:0] mario_x, mario_y;
    logic [7:0] vel_y;
    logic       on_ground, busy;

    logic       ft2 = 1'b0, jump2 = 1'b0, left2 = 1'b0, right2 = 1'b0;
    logic [9:0] x2, y2;
    logic [7:0] vy2;
    logic       og2, busy2;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    mario_motion u_dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick),
        .btn_left(btn_left), .btn_right(btn_right), .btn_jump(btn_jump),
        .mario_x(mario_x), .mario_y(mario_y), .vel_y(vel_y),
        .on_ground(on_ground), .busy(busy)
    );

    mario_motion #(.JUMP_VEL(40), .Y_MAX(120)) u_ceil (
        .clk(clk), .rst(rst), .frame_tick(ft2),
        .btn_left(left2), .btn_right(right2), .btn_jump(jump2),
        .mario_x(x2), .mario_y(y2), .vel_y(vy2),
        .on_ground(og2), .busy(busy2)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int ex, input int ey,
                           input int evy, input int eog);
        chk({tag, ".x"},  mario_x, ex);
        chk({tag, ".y"},  mario_y, ey);
        chk({tag, ".vy"}, $signed(vel_y), evy);
        chk({tag, ".og"}, on_ground, eog);
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic tick_a(input logic l, input logic r, input logic j);
        @(negedge clk);
        btn_left = l; btn_right = r; btn_jump = j; frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
        chk("busy_calc", busy, 1);
        @(negedge clk); chk("busy_commit", busy, 1);
        @(negedge clk); chk("busy_done", busy, 0);
    endtask

    task automatic tick_b(input logic j);
        @(negedge clk); jump2 = j; ft2 = 1'b1;
        @(negedge clk); ft2 = 1'b0;
        @(negedge clk);
        @(negedge clk); chk("ceil_busy_done", busy2, 0);
    endtask

    int ey  [0:25] = '{12, 23, 33, 42, 50, 57, 63, 68, 72, 75, 77, 78, 78,
                       77, 75, 72, 68, 63, 57, 50, 42, 33, 23, 13, 3, 0};
    int evy [0:25] = '{11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0, -1,
                       -2, -3, -4, -5, -6, -7, -8, -9, -10, -10, -10, -10, 0};

    initial begin
        int ex;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_out("reset", 100, 0, 0, 1);
        chk("reset.busy", busy, 0);
        chk("reset.ceil_y", y2, 0);
        chk("reset.ceil_og", og2, 1);

        // idle frames
        for (int k = 0; k < 5; k++) begin
            tick_a(0, 0, 0);
            chk_out($sformatf("idle%0d", k), 100, 0, 0, 1);
        end

        // walk right into the right wall
        ex = 100;
        for (int k = 1; k <= 200; k++) begin
            tick_a(0, 1, 0);
            ex = (ex + 3 > 582) ? 582 : ex + 3;
            chk($sformatf("right%0d.x", k), mario_x, ex);
        end
        chk("right_sat.x", mario_x, 582);
        tick_a(1, 1, 0);
        chk("both.x", mario_x, 582);
        tick_a(1, 1, 0);
        chk("both2.x", mario_x, 582);

        // walk left into the left wall
        do_reset();
        ex = 100;
        for (int k = 1; k <= 40; k++) begin
            tick_a(1, 0, 0);
            ex = (ex - 3 < 2) ? 2 : ex - 3;
            chk($sformatf("left%0d.x", k), mario_x, ex);
        end
        chk("left_sat.x", mario_x, 2);

        // full jump arc; second press on frame 24 exercises the buffer
        do_reset();
        for (int k = 1; k <= 26; k++) begin
            tick_a(0, 0, (k == 1) || (k == 24));
            chk_out($sformatf("jump%0d", k), 100, ey[k-1], evy[k-1],
                    (k == 26) ? 1 : 0);
        end
        tick_a(0, 0, 0);
`ifdef JUMP_BUFFER_EN
        chk_out("jump27_buffered", 100, 12, 11, 0);
`else
        chk_out("jump27_grounded", 100, 0, 0, 1);
`endif

        // ceiling instance: JUMP_VEL=40, Y_MAX=120 -> top at 104
        tick_b(1);
        chk("ceil1.y", y2, 40);
        chk("ceil1.vy", $signed(vy2), 39);
        tick_b(0);
        chk("ceil2.y", y2, 79);
        tick_b(0);
        chk("ceil3.y", y2, 104);
        chk("ceil3.vy", $signed(vy2), 0);
        chk("ceil3.og", og2, 0);
        tick_b(0);
        chk("ceil4.y", y2, 104);
        chk("ceil4.vy", $signed(vy2), -1);
        for (int k = 5; k <= 17; k++) tick_b(0);
        tick_b(0);
        chk("ceil18.y", y2, 9);
        chk("ceil18.vy", $signed(vy2), -10);
        tick_b(0);
        chk("ceil19.y", y2, 0);
        chk("ceil19.og", og2, 1);

        // reset between tick and commit discards the update
        do_reset();
        tick_a(0, 1, 0);
        chk("pre_rst.x", mario_x, 103);
        tick_a(0, 0, 1);
        chk("pre_rst.y", mario_y, 12);
        @(negedge clk); btn_jump = 1'b0; frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0; rst = 1'b1;
        chk("rst_mid.busy_before", busy, 1);
        @(negedge clk); rst = 1'b0;
        chk_out("rst_mid", 100, 0, 0, 1);
        chk("rst_mid.busy", busy, 0);
        repeat (4) @(negedge clk);
        chk_out("rst_mid_hold", 100, 0, 0, 1);
        chk("rst_mid_hold.busy", busy, 0);

        // tick while busy is ignored
        @(negedge clk); btn_right = 1'b1; frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
        chk("busy_tick.commit_busy", busy, 1);
        @(negedge clk);
        chk("busy_tick.busy", busy, 0);
        chk("busy_tick.x", mario_x, 103);
        repeat (3) @(negedge clk);
        chk("busy_tick.idle", busy, 0);
        chk("busy_tick.x_hold", mario_x, 103);

        // tick coincident with reset is dropped
        @(negedge clk); frame_tick = 1'b1; rst = 1'b1;
        @(negedge clk); frame_tick = 1'b0; rst = 1'b0;
        chk("tick_rst.busy", busy, 0);
        @(negedge clk);
        chk("tick_rst.busy2", busy, 0);
        chk("tick_rst.x", mario_x, 100);
        tick_a(0, 1, 0);
        chk("after_rst.x", mario_x, 103);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, vectors %0d", vecs);
        $fatal(1, "watchdog");
    end

endmodule
